// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped bank of up to 32 general-purpose I/O pins.
//
// A two-state access FSM (IDLE/ACK) serves one register access per request.
// Writes commit and read data is captured on the IDLE->ACK edge. reg_rdata is
// valid for the single ACK cycle and is zero otherwise.
//
// Pad inputs pass through a SYNC_STAGES-deep synchroniser. One history flop
// after the last stage holds the previous synchronised value, and events are
// detected from the two. Events latch into the sticky STATUS register, which
// is cleared by writing 1s to it (W1C). If an event and a clear hit the same
// bit in the same cycle, the event wins.
//
// Register map (word address):
//   0 DIR      rw  1 = pin driven
//   1 OUT      rw  output values
//   2 IN       ro  synchronised pad inputs
//   3 INTEN    rw  per-pin event enable
//   4 INTTYPE0 rw  mode bit 0
//   5 INTTYPE1 rw  mode bit 1
//   6 STATUS   rw1c latched events
//   7 OUT_TGL  wo  OUT ^= wdata; reads 0
// Event mode {INTTYPE1,INTTYPE0}: 00 level-high, 01 rising, 10 falling,
// 11 both edges. Bits [31:NUM_GPIO] read 0 and ignore writes.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   reg_req    in   register access request
//   reg_we     in   1 = write, 0 = read
//   reg_addr   in   [2:0] word address
//   reg_wdata  in   [31:0] write data
//   reg_ack    out  one-cycle access acknowledge
//   reg_rdata  out  [31:0] read data, valid while reg_ack = 1, else 0
//   gpio_in    in   [NUM_GPIO-1:0] asynchronous pad inputs
//   gpio_out   out  [NUM_GPIO-1:0] OUT register
//   gpio_dir   out  [NUM_GPIO-1:0] DIR register
//   irq_o      out  OR of all STATUS bits
module gpio_bank #(
  parameter int NUM_GPIO    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reg_req,
  input  logic                reg_we,
  input  logic [2:0]          reg_addr,
  input  logic [31:0]         reg_wdata,
  output logic                reg_ack,
  output logic [31:0]         reg_rdata,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_dir,
  output logic                irq_o
);

  localparam logic [2:0] A_DIR      = 3'd0;
  localparam logic [2:0] A_OUT      = 3'd1;
  localparam logic [2:0] A_IN       = 3'd2;
  localparam logic [2:0] A_INTEN    = 3'd3;
  localparam logic [2:0] A_INTTYPE0 = 3'd4;
  localparam logic [2:0] A_INTTYPE1 = 3'd5;
  localparam logic [2:0] A_STATUS   = 3'd6;
  localparam logic [2:0] A_OUT_TGL  = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_nxt;
  logic                  accept;
  logic                  wr_en;
  logic [NUM_GPIO-1:0]   wdata_n;

  logic [NUM_GPIO-1:0]   dir_q;
  logic [NUM_GPIO-1:0]   out_q;
  logic [NUM_GPIO-1:0]   inten_q;
  logic [NUM_GPIO-1:0]   type0_q;
  logic [NUM_GPIO-1:0]   type1_q;
  logic [NUM_GPIO-1:0]   status_q;
  logic [31:0]           rdata_q;
  logic [31:0]           rd_mux;

  logic [NUM_GPIO-1:0]   sync_p [SYNC_STAGES];
  logic [NUM_GPIO-1:0]   in_sync;
  logic [NUM_GPIO-1:0]   hist_q;
  logic [NUM_GPIO-1:0]   evt;
  logic [NUM_GPIO-1:0]   w1c;

  // Zero-extend a pin-wide value onto the 32-bit register bus.
  function automatic logic [31:0] zext(input logic [NUM_GPIO-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NUM_GPIO-1:0] = v;
    return r;
  endfunction

  // Per-pin event detection from the current and previous synchronised values.
  function automatic logic [NUM_GPIO-1:0] detect(
    input logic [NUM_GPIO-1:0] cur,
    input logic [NUM_GPIO-1:0] prev,
    input logic [NUM_GPIO-1:0] t0,
    input logic [NUM_GPIO-1:0] t1
  );
    logic [NUM_GPIO-1:0] e;
    logic [NUM_GPIO-1:0] rise;
    logic [NUM_GPIO-1:0] fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    e    = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      case ({t1[i], t0[i]})
        2'b00:   e[i] = cur[i];
        2'b01:   e[i] = rise[i];
        2'b10:   e[i] = fall[i];
        default: e[i] = rise[i] | fall[i];
      endcase
    end
    return e;
  endfunction

  // Access FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (reg_req) begin
          state_nxt = ACK;
          accept    = 1'b1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_en   = accept & reg_we;
  assign wdata_n = reg_wdata[NUM_GPIO-1:0];

  // Input synchroniser stages p0..p(SYNC_STAGES-1), then the history flop
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_p[k] <= '0;
      end
      hist_q <= '0;
    end else begin
      sync_p[0] <= gpio_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_p[k] <= sync_p[k-1];
      end
      hist_q <= in_sync;
    end
  end

  assign in_sync = sync_p[SYNC_STAGES-1];
  assign evt     = inten_q & detect(in_sync, hist_q, type0_q, type1_q);
  assign w1c     = (wr_en && reg_addr == A_STATUS) ? wdata_n : '0;

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      A_DIR:      rd_mux = zext(dir_q);
      A_OUT:      rd_mux = zext(out_q);
      A_IN:       rd_mux = zext(in_sync);
      A_INTEN:    rd_mux = zext(inten_q);
      A_INTTYPE0: rd_mux = zext(type0_q);
      A_INTTYPE1: rd_mux = zext(type1_q);
      A_STATUS:   rd_mux = zext(status_q);
      A_OUT_TGL:  rd_mux = '0;
      default:    rd_mux = '0;
    endcase
  end

  // Register file, STATUS and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q    <= '0;
      out_q    <= '0;
      inten_q  <= '0;
      type0_q  <= '0;
      type1_q  <= '0;
      status_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (wr_en) begin
        case (reg_addr)
          A_DIR:      dir_q   <= wdata_n;
          A_OUT:      out_q   <= wdata_n;
          A_INTEN:    inten_q <= wdata_n;
          A_INTTYPE0: type0_q <= wdata_n;
          A_INTTYPE1: type1_q <= wdata_n;
          A_OUT_TGL:  out_q   <= out_q ^ wdata_n;
          default:    ;
        endcase
      end
      // OR-ing evt after the clear makes a coincident event win.
      status_q <= (status_q & ~w1c) | evt;
      // Outside an accept this clears, so rdata is zero except during ACK.
      rdata_q  <= accept ? rd_mux : '0;
    end
  end

  assign reg_ack   = (state_q == ACK);
  assign reg_rdata = rdata_q;
  assign gpio_out  = out_q;
  assign gpio_dir  = dir_q;
  assign irq_o     = |status_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: one 32-pin instance (dut) and one 8-pin
// instance (dut8), both with a 2-stage synchroniser.
module tb_gpio_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        req32;
  logic        req8;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;

  logic        ack32;
  logic [31:0] rdata32;
  logic [31:0] gin32;
  logic [31:0] gout32;
  logic [31:0] gdir32;
  logic        irq32;

  logic        ack8;
  logic [31:0] rdata8;
  logic [7:0]  gin8;
  logic [7:0]  gout8;
  logic [7:0]  gdir8;
  logic        irq8;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  gpio_bank #(.NUM_GPIO(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .reg_req(req32), .reg_we(we), .reg_addr(addr),
    .reg_wdata(wdata), .reg_ack(ack32), .reg_rdata(rdata32),
    .gpio_in(gin32), .gpio_out(gout32), .gpio_dir(gdir32), .irq_o(irq32)
  );

  gpio_bank #(.NUM_GPIO(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .reg_req(req8), .reg_we(we), .reg_addr(addr),
    .reg_wdata(wdata), .reg_ack(ack8), .reg_rdata(rdata8),
    .gpio_in(gin8), .gpio_out(gout8), .gpio_dir(gdir8), .irq_o(irq8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Called at posedge+1 with the FSM in IDLE. Returns the read data seen in
  // the ACK cycle and leaves the bench at posedge+1 with the FSM back in IDLE.
  task automatic access(input bit d8, input bit w, input logic [2:0] a,
                        input logic [31:0] d, output logic [31:0] rdo);
    we    = w;
    addr  = a;
    wdata = d;
    if (d8) req8 = 1'b1; else req32 = 1'b1;
    @(posedge clk); #1;
    chk("ack_high", d8 ? {31'd0, ack8} : {31'd0, ack32}, 32'd1);
    rdo   = d8 ? rdata8 : rdata32;
    req8  = 1'b0;
    req32 = 1'b0;
    we    = 1'b0;
    wdata = '0;
    @(posedge clk); #1;
    chk("ack_low", d8 ? {31'd0, ack8} : {31'd0, ack32}, 32'd0);
    chk("rdata_idle", d8 ? rdata8 : rdata32, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    req32 = 1'b0;
    req8  = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    gin32 = '0;
    gin8  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack32}, 32'd0);
    chk("rst_rdata", rdata32, 32'd0);
    chk("rst_gout", gout32, 32'd0);
    chk("rst_gdir", gdir32, 32'd0);
    chk("rst_irq", {31'd0, irq32}, 32'd0);
    rst = 1'b0;

    // DIR / OUT write and readback
    access(0, 1, 3'd0, 32'h0000_00FF, rd);
    chk("gpio_dir", gdir32, 32'h0000_00FF);
    access(0, 1, 3'd1, 32'h0000_00A5, rd);
    chk("gpio_out", gout32, 32'h0000_00A5);
    access(0, 0, 3'd0, 32'h0, rd);
    chk("rd_dir", rd, 32'h0000_00FF);
    access(0, 0, 3'd1, 32'h0, rd);
    chk("rd_out", rd, 32'h0000_00A5);

    // OUT toggle
    access(0, 1, 3'd1, 32'h0000_00F0, rd);
    access(0, 1, 3'd7, 32'h0000_00FF, rd);
    chk("gpio_out_tgl", gout32, 32'h0000_000F);
    access(0, 0, 3'd7, 32'h0, rd);
    chk("rd_tgl", rd, 32'h0);
    access(0, 1, 3'd2, 32'hFFFF_FFFF, rd);
    access(0, 0, 3'd2, 32'h0, rd);
    chk("rd_in_ro", rd, 32'h0);

    // Rising edge on pin 3: irq exactly 3 edges after the input change
    access(0, 1, 3'd3, 32'h0000_0008, rd);
    access(0, 1, 3'd4, 32'h0000_0008, rd);
    chk("irq_quiet", {31'd0, irq32}, 32'd0);
    gin32[3] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("irq_2edges", {31'd0, irq32}, 32'd0);
    @(posedge clk); #1;
    chk("irq_3edges", {31'd0, irq32}, 32'd1);
    access(0, 0, 3'd6, 32'h0, rd);
    chk("rd_status_rise", rd, 32'h0000_0008);
    access(0, 0, 3'd2, 32'h0, rd);
    chk("rd_in", rd, 32'h0000_0008);
    access(0, 1, 3'd6, 32'h0000_0008, rd);
    chk("irq_w1c", {31'd0, irq32}, 32'd0);
    gin32[3] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("irq_no_fall", {31'd0, irq32}, 32'd0);
    access(0, 0, 3'd6, 32'h0, rd);
    chk("rd_status_fall", rd, 32'h0);

    // Both-edges on pin 0; W1C collides with a new edge
    access(0, 1, 3'd3, 32'h0000_0001, rd);
    access(0, 1, 3'd4, 32'h0000_0001, rd);
    access(0, 1, 3'd5, 32'h0000_0001, rd);
    gin32[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("irq_both_rise", {31'd0, irq32}, 32'd1);
    gin32[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    access(0, 1, 3'd6, 32'h0000_0001, rd);
    access(0, 0, 3'd6, 32'h0, rd);
    chk("set_wins", rd, 32'h0000_0001);
    access(0, 1, 3'd3, 32'h0, rd);
    access(0, 0, 3'd6, 32'h0, rd);
    chk("inten_off_keeps", rd, 32'h0000_0001);
    access(0, 1, 3'd6, 32'h0000_0001, rd);
    access(0, 0, 3'd6, 32'h0, rd);
    chk("w1c_clear", rd, 32'h0);
    chk("irq_cleared", {31'd0, irq32}, 32'd0);

    // 8-pin instance: upper bits masked, level-high re-sets after W1C
    access(1, 1, 3'd0, 32'hFFFF_FFFF, rd);
    chk("gpio_dir8", {24'd0, gdir8}, 32'h0000_00FF);
    access(1, 0, 3'd0, 32'h0, rd);
    chk("rd_dir8", rd, 32'h0000_00FF);
    access(1, 1, 3'd3, 32'h0000_0080, rd);
    gin8[7] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("irq8_level", {31'd0, irq8}, 32'd1);
    access(1, 1, 3'd6, 32'h0000_0080, rd);
    access(1, 0, 3'd6, 32'h0, rd);
    chk("level_reset", rd, 32'h0000_0080);
    chk("irq8_still", {31'd0, irq8}, 32'd1);

    // Reset during the ACK of a DIR write
    access(0, 1, 3'd3, 32'h0000_0001, rd);
    gin32[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("irq_pre_rst", {31'd0, irq32}, 32'd1);
    we    = 1'b1;
    addr  = 3'd0;
    wdata = 32'h0000_0055;
    req32 = 1'b1;
    @(posedge clk); #1;
    chk("ack_pre_rst", {31'd0, ack32}, 32'd1);
    chk("dir_pre_rst", gdir32, 32'h0000_0055);
    rst   = 1'b1;
    req32 = 1'b0;
    we    = 1'b0;
    @(posedge clk); #1;
    chk("rst_ack_abort", {31'd0, ack32}, 32'd0);
    chk("rst_dir_clr", gdir32, 32'h0);
    chk("rst_out_clr", gout32, 32'h0);
    chk("rst_irq_clr", {31'd0, irq32}, 32'd0);
    chk("rst_rdata_clr", rdata32, 32'h0);
    gin32 = '0;
    rst   = 1'b0;
    access(0, 0, 3'd0, 32'h0, rd);
    chk("post_rst_dir", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 SHALL have parameter NUM_GPIO, default 32, number of pins (legal 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal >= 2).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port reg_req  in  1  register access request.
REQ-006 SHALL have port reg_we  in  1  1 = write, 0 = read.
REQ-007 SHALL have port reg_addr  in  3  word address.
REQ-008 SHALL have port reg_wdata  in  32  write data.
REQ-009 SHALL have port reg_ack  out  1  one-cycle access acknowledge.
REQ-010 SHALL have port reg_rdata  out  32  read data, valid while reg_ack=1, else 0.
REQ-011 SHALL have port gpio_in  in  NUM_GPIO  asynchronous pad inputs.
REQ-012 SHALL have port gpio_out  out  NUM_GPIO  output values (= OUT register).
REQ-013 SHALL have port gpio_dir  out  NUM_GPIO  1 = pin driven (= DIR register).
REQ-014 SHALL have port irq_o  out  1  interrupt, = OR of all STATUS bits.

Function
REQ-015 Access FSM SHALL have states IDLE and ACK; IDLE->ACK when reg_req=1; ACK->IDLE unconditionally; reg_ack=1 only in ACK.
REQ-016 reg_req SHALL be ignored in ACK; master drops reg_req in the ack cycle; a held reg_req yields one access every 2 cycles.
REQ-017 Writes SHALL update the register on the IDLE->ACK edge; read data SHALL be captured on the same edge and presented during ACK.
REQ-018 Register map SHALL be: 0 DIR rw; 1 OUT rw; 2 IN ro; 3 INTEN rw; 4 INTTYPE0 rw; 5 INTTYPE1 rw; 6 STATUS rw1c; 7 OUT_TGL wo (OUT ^= wdata), reads 0.
REQ-019 Bits [31:NUM_GPIO] SHALL read 0 and ignore writes; writes to IN SHALL be ignored.
REQ-020 Each gpio_in bit SHALL pass through SYNC_STAGES flops; IN reflects the last stage; one further history flop holds the previous synchronised value.
REQ-021 Per-pin event mode {INTTYPE1,INTTYPE0} SHALL be: 00 level-high, 01 rising, 10 falling, 11 both edges, evaluated on synchronised value vs history.
REQ-022 STATUS[i] SHALL set on the clock after an event on pin i while INTEN[i]=1; level-high mode sets it every cycle the synchronised input is 1.
REQ-023 Latency: stable input change -> IN updated after SYNC_STAGES edges, STATUS set after SYNC_STAGES+1 edges, irq_o same cycle as STATUS.
REQ-024 Simultaneous event and W1C clear of the same bit SHALL leave the bit set (set wins).
REQ-025 Clearing INTEN[i] SHALL NOT clear STATUS[i]; changing INTTYPE SHALL NOT itself create an event.
REQ-026 Pulses shorter than one clk period MAY be missed; no event SHALL be produced without a change in synchronised value (edge modes).

Reset
REQ-027 While rst=1 on a clock edge: FSM->IDLE, reg_ack=0, reg_rdata=0, DIR/OUT/INTEN/INTTYPE0/INTTYPE1/STATUS=0, all synchroniser and history flops=0, gpio_out=0, gpio_dir=0, irq_o=0.
REQ-028 Reset asserted during ACK SHALL abort the access; a write already committed on the IDLE->ACK edge is cleared by reset.
REQ-029 After reset release, first access SHALL be accepted on the first cycle with reg_req=1.

Verification
REQ-030 Write DIR=0x0000_00FF, OUT=0xA5, read both -> gpio_dir=0xFF, gpio_out=0xA5, reads return 0xFF and 0xA5, reg_ack exactly 1 cycle after each req.
REQ-031 OUT=0xF0, write OUT_TGL=0xFF -> gpio_out=0x0F; read addr 7 returns 0.
REQ-032 INTEN[3]=1, mode 01, gpio_in[3] 0->1 -> STATUS=0x8 and irq_o=1 exactly 3 edges later (SYNC_STAGES=2); 1->0 gives no new event.
REQ-033 Mode 11 on pin 0, toggle pin, W1C STATUS=0x1 in same cycle as a new edge -> STATUS[0] remains 1; next W1C with no edge -> 0, irq_o=0.
REQ-034 NUM_GPIO=8: write DIR=0xFFFF_FFFF -> reads 0x0000_00FF; level-high on pin 7 held high -> STATUS[7] re-sets after W1C next cycle.
REQ-035 Assert rst during ACK of a DIR write -> next cycle reg_ack=0, DIR=0, irq_o=0, all outputs 0.
